// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68000 DMA bus arbiter.
package m68k_bus_pkg;

   localparam int MAX_NREQ = 4;
   localparam int OWN_W    = $clog2(MAX_NREQ);

   // Idle levels of the active-low bus handshake signals.
   localparam logic BR_N_RST    = 1'b1;
   localparam logic BGACK_N_RST = 1'b1;
   localparam logic SYNC_RST    = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_IDLE,
      OWN,
      RELEASE
   } arb_state_e;

endpackage

// File: rtl/m68k_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module m68k_rr_pick
   import m68k_bus_pkg::*;
#(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]  eligible,
   input  logic [OWN_W-1:0] ptr,
   output logic [OWN_W-1:0] idx,
   output logic             valid
);

   int              cand;
   logic [NREQ-1:0] shifted;

   // Scan from farthest to nearest so the nearest eligible index wins.
   always_comb begin
      idx     = '0;
      valid   = 1'b0;
      cand    = 0;
      shifted = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand    = (int'(ptr) + k) % NREQ;
         shifted = eligible >> cand;
         if (shifted[0]) begin
            idx   = cand[OWN_W-1:0];
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/m68k_bus_arbiter.sv
// Shares the 68000 bus between the CPU and NREQ DMA masters via BR/BG/BGACK.
//  state     | meaning
//  IDLE      | no DMA activity, CPU owns the bus
//  REQ       | BR asserted, waiting for BG
//  WAIT_IDLE | BG seen, waiting for AS and DTACK to go idle
//  OWN       | a DMA master owns the bus, tenure counting
//  RELEASE   | one-cycle handback, round-robin pointer advanced
module m68k_bus_arbiter
   import m68k_bus_pkg::*;
#(
   parameter int NREQ       = 2,
   parameter int MAX_TENURE = 256,
   parameter int CNT_W      = 9
) (
   input  logic             clk16,
   input  logic             reset_n,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  gnt,
   output logic [OWN_W-1:0] owner,
   output logic             timeout,
   output logic             br_n,
   input  logic             bg_n,
   output logic             bgack_n,
   input  logic             as_n,
   input  logic             dtack_n
);

   arb_state_e       state_q, state_d;
   logic [1:0]       bg_sync_q, bg_sync_d;
   logic [1:0]       as_sync_q, as_sync_d;
   logic [1:0]       dtk_sync_q, dtk_sync_d;
   logic             br_n_q, br_n_d;
   logic             bgack_n_q, bgack_n_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [OWN_W-1:0] owner_q, owner_d;
   logic             timeout_q, timeout_d;
   logic [OWN_W-1:0] rr_q, rr_d;
   logic [NREQ-1:0]  penalty_q, penalty_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             bg_s, as_s, dtk_s;
   logic [NREQ-1:0]  eligible;
   logic [OWN_W-1:0] pick_idx;
   logic             pick_valid;
   logic             req_own;
   logic             br_phase_q, br_phase_d;

   assign bg_s     = bg_sync_q[1];
   assign as_s     = as_sync_q[1];
   assign dtk_s    = dtk_sync_q[1];
   assign eligible = req & ~penalty_q;
   assign req_own  = |(req & gnt_q);

   assign bg_sync_d  = {bg_sync_q[0], bg_n};
   assign as_sync_d  = {as_sync_q[0], as_n};
   assign dtk_sync_d = {dtk_sync_q[0], dtack_n};

   m68k_rr_pick #(.NREQ(NREQ)) u_pick (
      .eligible (eligible),
      .ptr      (rr_q),
      .idx      (pick_idx),
      .valid    (pick_valid)
   );

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      owner_d   = owner_q;
      bgack_n_d = bgack_n_q;
      timeout_d = 1'b0;
      rr_d      = rr_q;
      cnt_d     = cnt_q;
      penalty_d = penalty_q & req;
      unique case (state_q)
         IDLE: begin
            if (|eligible) state_d = REQ;
         end
         REQ: begin
            if (!bg_s)                state_d = WAIT_IDLE;
            else if (eligible == '0)  state_d = IDLE;
         end
         WAIT_IDLE: begin
            if (eligible == '0) begin
               state_d = IDLE;
            end else if (as_s && dtk_s && pick_valid) begin
               state_d   = OWN;
               owner_d   = pick_idx;
               gnt_d     = NREQ'(1) << pick_idx;
               bgack_n_d = 1'b0;
               cnt_d     = '0;
            end
         end
         OWN: begin
            cnt_d = cnt_q + 1'b1;
            if (!req_own || cnt_q == CNT_W'(MAX_TENURE - 1)) begin
               state_d   = RELEASE;
               gnt_d     = '0;
               bgack_n_d = 1'b1;
               cnt_d     = '0;
               rr_d      = (owner_q == OWN_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
               // A normal release wins over a coincident tenure expiry.
               if (req_own) begin
                  timeout_d = 1'b1;
                  penalty_d = penalty_d | gnt_q;
               end
            end
         end
         RELEASE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // BR is driven only once the request has persisted for a full cycle.
   always_comb begin
      br_phase_d = (state_d == REQ) || (state_d == WAIT_IDLE);
      br_n_d     = !(br_phase_q && br_phase_d);
   end

   always_ff @(posedge clk16 or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         bg_sync_q  <= {2{SYNC_RST}};
         as_sync_q  <= {2{SYNC_RST}};
         dtk_sync_q <= {2{SYNC_RST}};
         br_n_q     <= BR_N_RST;
         bgack_n_q  <= BGACK_N_RST;
         gnt_q      <= '0;
         owner_q    <= '0;
         timeout_q  <= 1'b0;
         rr_q       <= '0;
         penalty_q  <= '0;
         cnt_q      <= '0;
         br_phase_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bg_sync_q  <= bg_sync_d;
         as_sync_q  <= as_sync_d;
         dtk_sync_q <= dtk_sync_d;
         br_n_q     <= br_n_d;
         bgack_n_q  <= bgack_n_d;
         gnt_q      <= gnt_d;
         owner_q    <= owner_d;
         timeout_q  <= timeout_d;
         rr_q       <= rr_d;
         penalty_q  <= penalty_d;
         cnt_q      <= cnt_d;
         br_phase_q <= br_phase_d;
      end
   end

   assign gnt     = gnt_q;
   assign owner   = owner_q;
   assign timeout = timeout_q;
   assign br_n    = br_n_q;
   assign bgack_n = bgack_n_q;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Bench for m68k_bus_arbiter: CPU BR/BG model plus a grant-order scoreboard.
module tb_m68k_bus_arbiter;

   localparam int NREQ       = 2;
   localparam int MAX_TENURE = 8;
   localparam int CNT_W      = 4;

   logic            clk16 = 1'b0;
   logic            reset_n;
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] gnt;
   logic [1:0]      owner;
   logic            timeout;
   logic            br_n;
   logic            bg_n;
   logic            bgack_n;
   logic            as_n;
   logic            dtack_n;

   int errors = 0;
   int checks = 0;
   int exp_q[$];
   int mon_exp;
   int br_cnt;
   logic [NREQ-1:0] gnt_prev = '0;
   logic [NREQ-1:0] exp_gnt;

   m68k_bus_arbiter #(.NREQ(NREQ), .MAX_TENURE(MAX_TENURE), .CNT_W(CNT_W)) dut (
      .clk16   (clk16),
      .reset_n (reset_n),
      .req     (req),
      .gnt     (gnt),
      .owner   (owner),
      .timeout (timeout),
      .br_n    (br_n),
      .bg_n    (bg_n),
      .bgack_n (bgack_n),
      .as_n    (as_n),
      .dtack_n (dtack_n)
   );

   initial forever #5 clk16 = ~clk16;

   // CPU model: grants the bus 3 cycles after BR falls, withdraws BG when BR rises.
   initial begin
      bg_n   = 1'b1;
      br_cnt = 0;
      forever begin
         @(posedge clk16);
         #1;
         if (br_n !== 1'b0) begin
            br_cnt = 0;
            bg_n   = 1'b1;
         end else if (br_cnt >= 3) begin
            bg_n = 1'b0;
         end else begin
            br_cnt++;
         end
      end
   end

   // Scoreboard: every new grant must match the next expected owner.
   always @(negedge clk16) begin
      if (gnt_prev == '0 && gnt != '0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL grant_unexpected: gnt=%b owner=%0d, required no grant", gnt, owner);
         end else begin
            mon_exp = exp_q.pop_front();
            exp_gnt = 2'b01 << mon_exp;
            if (owner !== 2'(mon_exp) || gnt !== exp_gnt) begin
               errors++;
               $display("FAIL grant_owner: gnt=%b owner=%0d, required gnt=%b owner=%0d",
                        gnt, owner, exp_gnt, mon_exp);
            end
         end
      end
      gnt_prev <= gnt;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk16);
         #2;
      end
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      req     = '0;
      as_n    = 1'b1;
      dtack_n = 1'b1;
      tick(3);
      reset_n = 1'b1;
      tick(1);
   endtask

   task automatic wait_grant(input string name);
      int n = 0;
      while (gnt === '0 && n < 200) begin
         tick(1);
         n++;
      end
      checks++;
      if (gnt === '0) begin
         errors++;
         $display("FAIL %s_wait_grant: gnt=%b after %0d cycles, required a grant", name, gnt, n);
      end
   endtask

   task automatic wait_bg_low(input string name);
      int n = 0;
      while (bg_n === 1'b1 && n < 200) begin
         tick(1);
         n++;
      end
      checks++;
      if (bg_n !== 1'b0) begin
         errors++;
         $display("FAIL %s_wait_bg: bg_n=%b after %0d cycles, required 0", name, bg_n, n);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks += 5;
      if (br_n !== 1'b1)    begin errors++; $display("FAIL reset_br_n: got %b, required 1", br_n); end
      if (bgack_n !== 1'b1) begin errors++; $display("FAIL reset_bgack_n: got %b, required 1", bgack_n); end
      if (gnt !== 2'b00)    begin errors++; $display("FAIL reset_gnt: got %b, required 00", gnt); end
      if (owner !== 2'd0)   begin errors++; $display("FAIL reset_owner: got %0d, required 0", owner); end
      if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b, required 0", timeout); end
   endtask

   task automatic test_single();
      apply_reset();
      exp_q.push_back(0);
      req = 2'b01;
      tick(1);
      checks++;
      if (br_n !== 1'b1) begin errors++; $display("FAIL single_br_early: br_n=%b, required 1", br_n); end
      tick(1);
      checks++;
      if (br_n !== 1'b0) begin errors++; $display("FAIL single_br_latency: br_n=%b, required 0", br_n); end
      wait_bg_low("single");
      tick(3);
      checks++;
      if (gnt !== 2'b00) begin errors++; $display("FAIL single_gnt_early: gnt=%b, required 00", gnt); end
      tick(1);
      checks += 3;
      if (gnt !== 2'b01)    begin errors++; $display("FAIL single_gnt: gnt=%b, required 01", gnt); end
      if (bgack_n !== 1'b0) begin errors++; $display("FAIL single_bgack: bgack_n=%b, required 0", bgack_n); end
      if (br_n !== 1'b1)    begin errors++; $display("FAIL single_br_release: br_n=%b, required 1", br_n); end
      tick(3);
      req = 2'b00;
      tick(1);
      checks += 3;
      if (gnt !== 2'b00)    begin errors++; $display("FAIL single_drop_gnt: gnt=%b, required 00", gnt); end
      if (bgack_n !== 1'b1) begin errors++; $display("FAIL single_drop_bgack: bgack_n=%b, required 1", bgack_n); end
      if (timeout !== 1'b0) begin errors++; $display("FAIL single_no_timeout: timeout=%b, required 0", timeout); end
      tick(3);
      checks++;
      if (br_n !== 1'b1) begin errors++; $display("FAIL single_idle_br: br_n=%b, required 1", br_n); end
   endtask

   task automatic test_busy_bus();
      as_n = 1'b0;
      exp_q.push_back(0);
      req = 2'b01;
      wait_bg_low("busy");
      for (int i = 0; i < 5; i++) begin
         tick(1);
         checks++;
         if (gnt !== 2'b00 || bgack_n !== 1'b1) begin
            errors++;
            $display("FAIL busy_hold: cycle %0d gnt=%b bgack_n=%b, required 00 and 1", i, gnt, bgack_n);
         end
      end
      as_n = 1'b1;
      tick(2);
      checks++;
      if (gnt !== 2'b00) begin errors++; $display("FAIL busy_gnt_early: gnt=%b, required 00", gnt); end
      tick(1);
      checks++;
      if (gnt !== 2'b01) begin errors++; $display("FAIL busy_gnt: gnt=%b, required 01", gnt); end
      req = 2'b00;
      tick(4);
   endtask

   task automatic test_round_robin();
      logic [NREQ-1:0] bit_m;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(i % 2);
         if (i == 0) req = 2'b11;
         wait_grant("rr");
         tick(4);
         bit_m = 2'b01 << (i % 2);
         req = req & ~bit_m;
         tick(1);
         checks++;
         if (gnt !== 2'b00) begin errors++; $display("FAIL rr_release: tenure %0d gnt=%b, required 00", i, gnt); end
         req = req | bit_m;
      end
      req = 2'b00;
      tick(6);
   endtask

   task automatic test_timeout();
      bit quiet_ok = 1'b1;
      apply_reset();
      exp_q.push_back(0);
      req = 2'b01;
      wait_grant("tmo");
      for (int i = 1; i < MAX_TENURE; i++) begin
         tick(1);
         checks++;
         if (gnt !== 2'b01 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL tmo_tenure: own cycle %0d gnt=%b timeout=%b, required 01 and 0", i + 1, gnt, timeout);
         end
      end
      tick(1);
      checks += 2;
      if (gnt !== 2'b00)    begin errors++; $display("FAIL tmo_gnt_drop: gnt=%b, required 00", gnt); end
      if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_pulse: timeout=%b, required 1", timeout); end
      tick(1);
      checks++;
      if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_pulse_width: timeout=%b, required 0", timeout); end
      for (int i = 0; i < 30; i++) begin
         tick(1);
         if (gnt !== 2'b00 || br_n !== 1'b1) quiet_ok = 1'b0;
      end
      checks++;
      if (!quiet_ok) begin errors++; $display("FAIL tmo_penalty: re-requested while penalised, required gnt=00 br_n=1"); end
      req = 2'b00;
      tick(1);
      exp_q.push_back(0);
      req = 2'b01;
      wait_grant("tmo_regrant");
      req = 2'b00;
      tick(4);
   endtask

   task automatic test_withdraw();
      bit quiet_ok = 1'b1;
      req = 2'b01;
      tick(2);
      checks++;
      if (br_n !== 1'b0) begin errors++; $display("FAIL wd_br_low: br_n=%b, required 0", br_n); end
      req = 2'b00;
      tick(1);
      checks++;
      if (br_n !== 1'b1) begin errors++; $display("FAIL wd_br_high: br_n=%b, required 1", br_n); end
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (gnt !== 2'b00 || bgack_n !== 1'b1 || br_n !== 1'b1) quiet_ok = 1'b0;
      end
      checks++;
      if (!quiet_ok) begin errors++; $display("FAIL wd_idle: activity after withdrawal, required gnt=00 bgack_n=1 br_n=1"); end
   endtask

   task automatic test_reset_own();
      exp_q.push_back(0);
      req = 2'b01;
      wait_grant("rst_own");
      tick(2);
      #1;
      reset_n = 1'b0;
      #1;
      checks += 3;
      if (gnt !== 2'b00)    begin errors++; $display("FAIL rst_own_gnt: gnt=%b, required 00", gnt); end
      if (bgack_n !== 1'b1) begin errors++; $display("FAIL rst_own_bgack: bgack_n=%b, required 1", bgack_n); end
      if (br_n !== 1'b1)    begin errors++; $display("FAIL rst_own_br: br_n=%b, required 1", br_n); end
      req = 2'b00;
      tick(2);
      reset_n = 1'b1;
      tick(2);
   endtask

   initial begin
      reset_n = 1'b0;
      req     = '0;
      as_n    = 1'b1;
      dtack_n = 1'b1;
      test_reset();
      test_single();
      test_busy_bus();
      test_round_robin();
      test_timeout();
      test_withdraw();
      test_reset_own();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d grants outstanding, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
